// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: source lines, configuration port and claim/complete handshake
// between the SoC/core side (master) and the interrupt arbiter (slave).
interface irq_arbiter_if #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRIO_W  = 3
);
    logic [NUM_SRC-1:0] src_irq_i;
    logic               cfg_we_i;
    logic [7:0]         cfg_idx_i;
    logic               cfg_en_i;
    logic [PRIO_W-1:0]  cfg_prio_i;
    logic               claim_i;
    logic               complete_i;
    logic [7:0]         complete_id_i;
    logic               irq_req_o;
    logic [7:0]         irq_id_o;
    logic [7:0]         active_id_o;
    logic               complete_err_o;

    modport master (
        output src_irq_i, cfg_we_i, cfg_idx_i, cfg_en_i, cfg_prio_i,
        output claim_i, complete_i, complete_id_i,
        input  irq_req_o, irq_id_o, active_id_o, complete_err_o
    );

    modport slave (
        input  src_irq_i, cfg_we_i, cfg_idx_i, cfg_en_i, cfg_prio_i,
        input  claim_i, complete_i, complete_id_i,
        output irq_req_o, irq_id_o, active_id_o, complete_err_o
    );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: arbitrates NUM_SRC interrupt sources into one request/ID pair,
// serialised by a claim/complete handshake (one interrupt in flight, no nesting).
// Optional macro IRQ_EDGE_TRIG_EN: gateways fire on rising edges instead of levels.
module irq_arbiter #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRIO_W  = 3
) (
    input logic          clk,
    input logic          rst_n,
    irq_arbiter_if.slave bus
);
    localparam int unsigned ID_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_REQ     = 3'b010,
        S_SERVICE = 3'b100
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_SRC-1:0]             pend_q, pend_d;
    logic [NUM_SRC-1:0]             insvc_q, insvc_d;
    logic [NUM_SRC-1:0]             en_q, en_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [PRIO_W-1:0]              thr_q, thr_d;
    logic                           req_q, req_d;
    logic                           err_q, err_d;
    logic [ID_W-1:0]                id_q, id_d;
    logic [ID_W-1:0]                act_q, act_d;

    logic [NUM_SRC-1:0] fire, elig, sel_req, sel_act, claim_mask, done_mask;
    logic               any_elig, req_elig;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;

`ifdef IRQ_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;

    assign src_prev_d = bus.src_irq_i;
    assign fire       = bus.src_irq_i & ~src_prev_q;

    // Previous line value per source for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_prev_q <= '0;
        else        src_prev_q <= src_prev_d;
    end
`else
    assign fire = bus.src_irq_i;
`endif

    // Eligibility, winner (highest priority, lowest ID on ties) and ID decodes
    always_comb begin
        elig     = '0;
        sel_req  = '0;
        sel_act  = '0;
        win_id   = '0;
        win_prio = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            elig[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_q);
            if (elig[i] && (prio_q[i] > win_prio)) begin
                win_prio = prio_q[i];
                win_id   = ID_W'(i + 1);
            end
            sel_req[i] = (id_q == ID_W'(i + 1));
            sel_act[i] = (act_q == ID_W'(i + 1));
        end
        any_elig = |elig;
        req_elig = |(elig & sel_req);
    end

    // Handshake FSM: next state and registered outputs
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        id_d       = id_q;
        act_d      = act_q;
        err_d      = 1'b0;
        claim_mask = '0;
        done_mask  = '0;
        case (state_q)
            S_IDLE: begin
                req_d = 1'b0;
                err_d = bus.complete_i;
                if (any_elig) begin
                    id_d    = win_id;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                err_d = bus.complete_i;
                if (bus.claim_i) begin
                    claim_mask = sel_req;
                    act_d      = id_q;
                    req_d      = 1'b0;
                    state_d    = S_SERVICE;
                end else if (!req_elig) begin
                    req_d   = 1'b0;
                    id_d    = '0;
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (bus.complete_i) begin
                    if (bus.complete_id_i == act_q) begin
                        done_mask = sel_act;
                        act_d     = '0;
                        id_d      = '0;
                        state_d   = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                id_d    = '0;
                act_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Gateway, pending/in-service bookkeeping and configuration writes
    always_comb begin
        pend_d  = (pend_q | (fire & ~insvc_q)) & ~claim_mask;
        insvc_d = (insvc_q | claim_mask) & ~done_mask;
        en_d    = en_q;
        prio_d  = prio_q;
        thr_d   = thr_q;
        if (bus.cfg_we_i) begin
            if (bus.cfg_idx_i == '0) begin
                thr_d = bus.cfg_prio_i;
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (bus.cfg_idx_i == ID_W'(i + 1)) begin
                    en_d[i]   = bus.cfg_en_i;
                    prio_d[i] = bus.cfg_prio_i;
                end
            end
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            insvc_q <= '0;
            en_q    <= '0;
            prio_q  <= '0;
            thr_q   <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            insvc_q <= insvc_d;
            en_q    <= en_d;
            prio_q  <= prio_d;
            thr_q   <= thr_d;
            req_q   <= req_d;
            err_q   <= err_d;
            id_q    <= id_d;
            act_q   <= act_d;
        end
    end

    assign bus.irq_req_o      = req_q;
    assign bus.irq_id_o       = id_q;
    assign bus.active_id_o    = act_q;
    assign bus.complete_err_o = err_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed vector table, hand-written corner sequences and a
// randomized run compared against a per-source lifecycle model.
module tb_irq_arbiter;
    localparam int unsigned NUM_SRC = 16;
    localparam int unsigned PRIO_W  = 3;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    irq_arbiter_if #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) bus_if ();

    irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each source is quiet (0), pending (1) or in service (2); the arbiter
    // is described only by what it currently offers and what is active.
    int m_st   [NUM_SRC+1];
    bit m_en   [NUM_SRC+1];
    int m_pr   [NUM_SRC+1];
    bit m_prev [NUM_SRC+1];
    int m_thr, m_offer, m_act, m_best, m_bp;
    bit m_err, m_fire;

    function automatic bit m_elig(int id);
        return (m_st[id] == 1) && m_en[id] && (m_pr[id] > m_thr);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int id = 0; id <= NUM_SRC; id++) begin
                m_st[id] = 0; m_en[id] = 0; m_pr[id] = 0; m_prev[id] = 0;
            end
            m_thr = 0; m_offer = 0; m_act = 0; m_err = 0;
        end else begin
            m_best = 0; m_bp = 0;
            for (int id = 1; id <= NUM_SRC; id++)
                if (m_elig(id) && m_pr[id] > m_bp) begin m_best = id; m_bp = m_pr[id]; end
            for (int id = 1; id <= NUM_SRC; id++) begin
`ifdef IRQ_EDGE_TRIG_EN
                m_fire = bus_if.src_irq_i[id-1] && !m_prev[id];
`else
                m_fire = bus_if.src_irq_i[id-1];
`endif
                if (m_fire && m_st[id] == 0) m_st[id] = 1;
                m_prev[id] = bus_if.src_irq_i[id-1];
            end
            m_err = 0;
            if (m_act != 0) begin
                if (bus_if.complete_i) begin
                    if (int'(bus_if.complete_id_i) == m_act) begin
                        m_st[m_act] = 0; m_act = 0; m_offer = 0;
                    end else m_err = 1;
                end
            end else if (m_offer != 0) begin
                m_err = bus_if.complete_i;
                if (bus_if.claim_i) begin
                    m_st[m_offer] = 2; m_act = m_offer;
                end else if (!m_elig(m_offer)) m_offer = 0;
            end else begin
                m_err = bus_if.complete_i;
                m_offer = m_best;
            end
            if (bus_if.cfg_we_i) begin
                if (bus_if.cfg_idx_i == 8'd0) m_thr = int'(bus_if.cfg_prio_i);
                else if (int'(bus_if.cfg_idx_i) <= NUM_SRC) begin
                    m_en[bus_if.cfg_idx_i] = bus_if.cfg_en_i;
                    m_pr[bus_if.cfg_idx_i] = int'(bus_if.cfg_prio_i);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk4(string name, logic req, logic [7:0] id, logic [7:0] act, logic err);
        chk({name, ".req"}, 32'(bus_if.irq_req_o), 32'(req));
        chk({name, ".id"},  32'(bus_if.irq_id_o), 32'(id));
        chk({name, ".act"}, 32'(bus_if.active_id_o), 32'(act));
        chk({name, ".err"}, 32'(bus_if.complete_err_o), 32'(err));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(logic [15:0] src, logic we = 0, logic [7:0] idx = 0, logic en = 0,
                        logic [2:0] prio = 0, logic claim = 0, logic cmp = 0, logic [7:0] cid = 0);
        bus_if.src_irq_i     = src;
        bus_if.cfg_we_i      = we;
        bus_if.cfg_idx_i     = idx;
        bus_if.cfg_en_i      = en;
        bus_if.cfg_prio_i    = prio;
        bus_if.claim_i       = claim;
        bus_if.complete_i    = cmp;
        bus_if.complete_id_i = cid;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] src;
        logic        we;
        logic [7:0]  idx;
        logic        en;
        logic [2:0]  prio;
        logic        claim;
        logic        cmp;
        logic [7:0]  cid;
        logic        req;
        logic [7:0]  id;
        logic [7:0]  act;
        logic        err;
    } vec_t;

    function automatic vec_t row(logic [15:0] src, logic we, logic [7:0] idx, logic en,
                                 logic [2:0] prio, logic claim, logic cmp, logic [7:0] cid,
                                 logic req, logic [7:0] id, logic [7:0] act, logic err);
        vec_t v;
        v.src = src; v.we = we; v.idx = idx; v.en = en; v.prio = prio;
        v.claim = claim; v.cmp = cmp; v.cid = cid;
        v.req = req; v.id = id; v.act = act; v.err = err;
        return v;
    endfunction

    vec_t tbl[$];
    bit   rnd_cmp;

    initial begin
        rst_n = 1'b0;
        bus_if.src_irq_i = '0; bus_if.cfg_we_i = 0; bus_if.cfg_idx_i = '0;
        bus_if.cfg_en_i = 0; bus_if.cfg_prio_i = '0; bus_if.claim_i = 0;
        bus_if.complete_i = 0; bus_if.complete_id_i = '0;
        repeat (2) @(posedge clk);
        #1 chk4("reset", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // src, we, idx, en, prio, claim, cmp, cid | req, id, act, err
        tbl.push_back(row(16'h0000, 1,  3, 1, 2, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0004, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   1, 3, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 1, 0, 0,   0, 3, 3, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   0, 3, 3, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 1, 3,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 1,  2, 1, 5, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 1,  7, 1, 5, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 1,  9, 1, 4, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0142, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0142, 0,  0, 0, 0, 0, 0, 0,   1, 2, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 1, 0, 0,   0, 2, 2, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 1, 2,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   1, 7, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 1, 0, 0,   0, 7, 7, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 1, 7,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   1, 9, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 1, 0, 0,   0, 9, 9, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 1, 9,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 1, 0,   0, 0, 0, 1));
        tbl.push_back(row(16'h0000, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].src, tbl[i].we, tbl[i].idx, tbl[i].en, tbl[i].prio,
                 tbl[i].claim, tbl[i].cmp, tbl[i].cid);
            chk4($sformatf("tbl%0d", i), tbl[i].req, tbl[i].id, tbl[i].act, tbl[i].err);
        end

        // Threshold masks ID5 until lowered below its priority
        step(16'h0000, 1, 0, 0, 4);
        step(16'h0000, 1, 5, 1, 4);
        step(16'h0010);
        step(16'h0000);                 chk4("thr_mask", 0, 0, 0, 0);
        step(16'h0000);                 chk4("thr_mask2", 0, 0, 0, 0);
        step(16'h0000, 1, 0, 0, 3);     chk4("thr_write", 0, 0, 0, 0);
        step(16'h0000);                 chk4("thr_req", 1, 5, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 1);  chk4("thr_claim", 0, 5, 5, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 5); chk4("thr_done", 0, 0, 0, 0);
        step(16'h0000, 1, 0, 0, 0);

        // Disable while requested withdraws; re-enable re-requests from retained pending
        step(16'h0000, 1, 4, 1, 3);
        step(16'h0008);
        step(16'h0000);                 chk4("dis_req", 1, 4, 0, 0);
        step(16'h0000, 1, 4, 0, 3);     chk4("dis_write", 1, 4, 0, 0);
        step(16'h0000);                 chk4("dis_drop", 0, 0, 0, 0);
        step(16'h0000, 1, 4, 1, 3);     chk4("reen_write", 0, 0, 0, 0);
        step(16'h0000);                 chk4("reen_req", 1, 4, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 1);  chk4("reen_claim", 0, 4, 4, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 4); chk4("reen_done", 0, 0, 0, 0);

        // Rejected completes: in S_REQ and with a wrong ID in service
        step(16'h0000, 1, 6, 1, 1);
        step(16'h0020);
        step(16'h0000);                 chk4("bad_req", 1, 6, 0, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 6); chk4("cmp_in_req", 1, 6, 0, 1);
        step(16'h0000, 0, 0, 0, 0, 1);  chk4("bad_claim", 0, 6, 6, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 5); chk4("bad_id", 0, 6, 6, 1);
        step(16'h0000);                 chk4("bad_hold", 0, 6, 6, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 6); chk4("good_id", 0, 0, 0, 0);

        // Level line held high across complete
        step(16'h0000, 1, 10, 1, 2);
        step(16'h0200);
        step(16'h0200);                 chk4("lvl_req", 1, 10, 0, 0);
        step(16'h0200, 0, 0, 0, 0, 1);  chk4("lvl_claim", 0, 10, 10, 0);
        step(16'h0200);                 chk4("lvl_svc", 0, 10, 10, 0);
        step(16'h0200, 0, 0, 0, 0, 0, 1, 10); chk4("lvl_done", 0, 0, 0, 0);
        step(16'h0200);                 chk4("lvl_after1", 0, 0, 0, 0);
`ifdef IRQ_EDGE_TRIG_EN
        step(16'h0200);                 chk4("edge_after2", 0, 0, 0, 0);
        step(16'h0200);                 chk4("edge_after3", 0, 0, 0, 0);
        step(16'h0000);                 chk4("edge_fall", 0, 0, 0, 0);
        step(16'h0200);                 chk4("edge_rise", 0, 0, 0, 0);
        step(16'h0200);                 chk4("edge_rereq", 1, 10, 0, 0);
`else
        step(16'h0200);                 chk4("lvl_rereq", 1, 10, 0, 0);
`endif
        step(16'h0000, 0, 0, 0, 0, 1);  chk4("rereq_claim", 0, 10, 10, 0);
        step(16'h0000, 0, 0, 0, 0, 0, 1, 10); chk4("rereq_done", 0, 0, 0, 0);

        // Asynchronous reset while requesting; configuration is lost
        step(16'h0004);
        step(16'h0000);                 chk4("rst_pre", 1, 3, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk4("rst_async", 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        step(16'h0004);
        step(16'h0004);                 chk4("rst_cfg_lost", 0, 0, 0, 0);
        step(16'h0000);

        // Randomized run against the model
        for (int id = 1; id <= NUM_SRC; id++)
            step(16'h0000, 1, 8'(id), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        step(16'h0000, 1, 0, 0, 3'($urandom_range(0, 2)));
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] idx;
            logic [7:0] cid;
            idx = 8'($urandom_range(0, NUM_SRC + 2));
            rnd_cmp = ($urandom_range(0, 3) == 0);
            cid = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, NUM_SRC + 1)) : 8'(m_act);
            step(16'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 15) == 0), idx, 1'($urandom_range(0, 3) != 0),
                 (idx == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), rnd_cmp, cid);
            chk($sformatf("rnd%0d.req", c), 32'(bus_if.irq_req_o), 32'((m_offer != 0) && (m_act == 0)));
            chk($sformatf("rnd%0d.id", c),  32'(bus_if.irq_id_o), 32'(m_offer));
            chk($sformatf("rnd%0d.act", c), 32'(bus_if.active_id_o), 32'(m_act));
            chk($sformatf("rnd%0d.err", c), 32'(bus_if.complete_err_o), 32'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
